// File: rtl/count_mon_pkg.sv
// Shared types and defaults for the count window monitor.
package count_mon_pkg;

  typedef enum logic {IDLE, WATCH} mon_state_e;

  localparam logic [7:0] ERR_MAX = 8'd255;

  localparam int unsigned DEF_CNT_W   = 4;
  localparam int unsigned DEF_TARGET  = 4'hA;
  localparam int unsigned DEF_MAX_CYC = 10;

endpackage

// File: rtl/count_window_monitor_sat_counter.sv
// Purpose: up-counter that sticks at all-ones instead of wrapping.
// Latency: value updates on the clock after inc.
// Backpressure: none; inc is a single-cycle strobe.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (inc && (value != {W{1'b1}})) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/count_window_monitor.sv
// Purpose: per start, watch count for TARGET within MAX_CYC cycles; pulse hit/timeout.
// Latency: hit/timeout pulse one clock after the deciding edge; busy drops on that edge.
// Backpressure: none; start is only accepted while idle.
module count_window_monitor
  import count_mon_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned TARGET  = DEF_TARGET,
  parameter int unsigned MAX_CYC = DEF_MAX_CYC,
  parameter int unsigned WIN_W   = $clog2(MAX_CYC + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             hit,
  output logic             timeout,
  output logic [WIN_W-1:0] hit_latency,
  output logic             wrap_seen,
  output logic [7:0]       err_cnt
);

  generate
    if (MAX_CYC < 1 || MAX_CYC > 255) begin : g_bad_max_cyc
      $error("count_window_monitor: MAX_CYC must be in 1..255");
    end
    if (TARGET >= (1 << CNT_W)) begin : g_bad_target
      $error("count_window_monitor: TARGET does not fit in CNT_W bits");
    end
  endgenerate

  localparam logic [CNT_W-1:0] TGT  = CNT_W'(TARGET);
  localparam logic [WIN_W-1:0] LAST = WIN_W'(MAX_CYC);

  mon_state_e       state;
  logic [WIN_W-1:0] cyc;
  logic [WIN_W-1:0] k;
  logic [CNT_W-1:0] prev;
  logic             watching;
  logic             match;
  logic             expire;

  // k is the 1-based index of the current window cycle.
  assign k        = cyc + 1'b1;
  assign watching = (state == WATCH);
  assign match    = (count == TGT);
  assign expire   = watching && !match && (k == LAST);
  assign busy     = watching;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cyc         <= '0;
      prev        <= '0;
      hit         <= 1'b0;
      timeout     <= 1'b0;
      hit_latency <= '0;
      wrap_seen   <= 1'b0;
    end else begin
      hit     <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= WATCH;
            cyc       <= '0;
            prev      <= count;
            wrap_seen <= 1'b0;
          end
        end
        WATCH: begin
          prev <= count;
          if (count < prev) begin
            wrap_seen <= 1'b1;
          end
          if (match) begin
            hit         <= 1'b1;
            hit_latency <= k;
            state       <= IDLE;
          end else if (k == LAST) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            cyc <= k;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sat_counter #(.W($bits(ERR_MAX))) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (expire),
    .value (err_cnt)
  );

endmodule

// File: tb/tb_count_window_monitor.sv
// Directed bench for count_window_monitor with default parameters (CNT_W=4, TARGET=10, MAX_CYC=10).
module tb_count_window_monitor;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] count;
  logic       busy;
  logic       hit;
  logic       timeout;
  logic [3:0] hit_latency;
  logic       wrap_seen;
  logic [7:0] err_cnt;

  int tests;
  int fails;

  count_window_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .count       (count),
    .busy        (busy),
    .hit         (hit),
    .timeout     (timeout),
    .hit_latency (hit_latency),
    .wrap_seen   (wrap_seen),
    .err_cnt     (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({busy, hit, timeout, hit_latency, wrap_seen, err_cnt} !== 16'h0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b hit=%b to=%b lat=%0d wrap=%b err=%0d, want all 0",
               busy, hit, timeout, hit_latency, wrap_seen, err_cnt);
    end
    step();
    reset = 1'b0;
    step();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_ramp();
    count = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      count = 4'(k);
      step();
      if (k < 10) begin
        tests++;
        if (busy !== 1'b1 || hit !== 1'b0) begin
          fails++;
          $display("FAIL ramp_k%0d: busy=%b hit=%b want busy=1 hit=0", k, busy, hit);
        end
      end
    end
    tests++;
    if (hit !== 1'b1 || busy !== 1'b0 || timeout !== 1'b0 || hit_latency !== 4'd10) begin
      fails++;
      $display("FAIL ramp_hit: hit=%b busy=%b to=%b lat=%0d want 1 0 0 10",
               hit, busy, timeout, hit_latency);
    end
    count = 4'd0;
    step();
    tests++;
    if (hit !== 1'b0 || err_cnt !== 8'd0 || wrap_seen !== 1'b0 || hit_latency !== 4'd10) begin
      fails++;
      $display("FAIL ramp_after: hit=%b err=%0d wrap=%b lat=%0d want 0 0 0 10",
               hit, err_cnt, wrap_seen, hit_latency);
    end
  endtask

  // start is pulsed mid-window; it must not restart the window.
  task automatic test_stuck();
    count = 4'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      start = (k == 5);
      step();
      if (k < 10) begin
        tests++;
        if (busy !== 1'b1 || timeout !== 1'b0 || hit !== 1'b0) begin
          fails++;
          $display("FAIL stuck_k%0d: busy=%b to=%b hit=%b want 1 0 0", k, busy, timeout, hit);
        end
      end
    end
    start = 1'b0;
    tests++;
    if (timeout !== 1'b1 || hit !== 1'b0 || busy !== 1'b0 || err_cnt !== 8'd1) begin
      fails++;
      $display("FAIL stuck_timeout: to=%b hit=%b busy=%b err=%0d want 1 0 0 1",
               timeout, hit, busy, err_cnt);
    end
    step();
    tests++;
    if (timeout !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL stuck_pulse_width: to=%b busy=%b want 0 0", timeout, busy);
    end
  endtask

  task automatic test_start_cycle_value();
    int hits;
    hits = 0;
    count = 4'd10; start = 1'b1;
    step();
    start = 1'b0;
    count = 4'd11;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (hit === 1'b1) hits++;
    end
    tests++;
    if (hits != 0 || timeout !== 1'b1 || err_cnt !== 8'd2 || wrap_seen !== 1'b0) begin
      fails++;
      $display("FAIL start_value: hits=%0d to=%b err=%0d wrap=%b want 0 1 2 0",
               hits, timeout, err_cnt, wrap_seen);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] seq [10];
    seq = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    count = 4'd13; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      count = seq[k-1];
      step();
      if (k == 2) begin
        tests++;
        if (wrap_seen !== 1'b0) begin
          fails++;
          $display("FAIL wrap_early: wrap=%b want 0", wrap_seen);
        end
      end
      if (k == 3) begin
        tests++;
        if (wrap_seen !== 1'b1) begin
          fails++;
          $display("FAIL wrap_detect: wrap=%b want 1", wrap_seen);
        end
      end
    end
    tests++;
    if (timeout !== 1'b1 || wrap_seen !== 1'b1 || err_cnt !== 8'd3) begin
      fails++;
      $display("FAIL wrap_end: to=%b wrap=%b err=%0d want 1 1 3", timeout, wrap_seen, err_cnt);
    end
    count = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    tests++;
    if (wrap_seen !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL wrap_clear: wrap=%b busy=%b want 0 1", wrap_seen, busy);
    end
    count = 4'd10;
    step();
    tests++;
    if (hit !== 1'b1 || hit_latency !== 4'd1 || err_cnt !== 8'd3) begin
      fails++;
      $display("FAIL hit_k1: hit=%b lat=%0d err=%0d want 1 1 3", hit, hit_latency, err_cnt);
    end
    count = 4'd0;
    step();
  endtask

  task automatic test_reset_mid_window();
    count = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    count = 4'd3;
    for (int k = 1; k <= 4; k++) step();
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || hit !== 1'b0 || timeout !== 1'b0 || err_cnt !== 8'd0 || hit_latency !== 4'd0) begin
      fails++;
      $display("FAIL reset_mid: busy=%b hit=%b to=%b err=%0d lat=%0d want all 0",
               busy, hit, timeout, err_cnt, hit_latency);
    end
    step();
    reset = 1'b0;
    step();
    tests++;
    if (hit !== 1'b0 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_pulse: hit=%b to=%b want 0 0", hit, timeout);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) step();
    tests++;
    if (busy !== 1'b1 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL fresh_window_k9: busy=%b to=%b want 1 0", busy, timeout);
    end
    step();
    tests++;
    if (timeout !== 1'b1 || err_cnt !== 8'd1) begin
      fails++;
      $display("FAIL fresh_window_end: to=%b err=%0d want 1 1", timeout, err_cnt);
    end
    step();
  endtask

  // start held high: each window is one accept cycle plus ten watch cycles.
  task automatic test_back_to_back();
    int n_to;
    int n_hit;
    int late;
    n_to = 0; n_hit = 0; late = 0;
    count = 4'd3; start = 1'b1;
    for (int s = 1; s <= 260 * 11; s++) begin
      step();
      if (hit === 1'b1) n_hit++;
      if (timeout === 1'b1) begin
        n_to++;
        if (s != n_to * 11) late++;
        if (n_to == 253) begin
          tests++;
          if (err_cnt !== 8'd254) begin
            fails++;
            $display("FAIL sat_254: err=%0d want 254", err_cnt);
          end
        end
        if (n_to == 254) begin
          tests++;
          if (err_cnt !== 8'd255) begin
            fails++;
            $display("FAIL sat_255: err=%0d want 255", err_cnt);
          end
        end
      end
    end
    start = 1'b0;
    tests++;
    if (n_to != 260 || n_hit != 0 || late != 0) begin
      fails++;
      $display("FAIL back_to_back: timeouts=%0d hits=%0d misplaced=%0d want 260 0 0", n_to, n_hit, late);
    end
    tests++;
    if (err_cnt !== 8'd255) begin
      fails++;
      $display("FAIL sat_hold: err=%0d want 255", err_cnt);
    end
    step();
    tests++;
    if (busy !== 1'b0 || err_cnt !== 8'd255) begin
      fails++;
      $display("FAIL sat_idle: busy=%b err=%0d want 0 255", busy, err_cnt);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    start = 1'b0;
    count = 4'd0;
    test_reset();
    test_ramp();
    test_stuck();
    test_start_cycle_value();
    test_wrap();
    test_reset_mid_window();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
